fwd_sel_unit: RTL and testbench
===============================

# fwd_sel_unit

Forwarding-select and load-use hazard unit for the redirect (forwarding) pipeline. It tracks destination-register metadata for the instructions in EX, MEM and WB. For each instruction leaving ID, it produces the registered 2-bit `choice` codes that drive the EX-stage operand `MUX_4` selectors. It also raises a one-cycle stall on load-use hazards and counts stall cycles for the on-board display.

## Interface
Parameters:
- `REG_W`, 5: register-index width.
- `CNT_W`, 16: stall-counter width.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `id_rs`, `id_rt` in REG_W: source indices of the instruction in ID.
- `id_rs_used`, `id_rt_used` in 1: the source is actually read.
- `id_rd` in REG_W: destination index of the ID instruction.
- `id_regwrite` in 1: the ID instruction writes the register file.
- `id_memread` in 1: the ID instruction is a load.
- `flush` in 1: taken branch/jump; the instruction in ID becomes a bubble.
- `ex_rs_sel`, `ex_rt_sel` out 2: operand mux `choice` for the instruction in EX.
- `stall` out 1: hold PC and IF/ID, inject a bubble into ID/EX.
- `stall_cnt` out CNT_W: saturating count of stall cycles.

## Operation
- Internal stage records `ex_*`, `mem_*` and `wb_*`, each holding `{rd, regwrite, memread}`. A record is forwardable only if `regwrite=1` and `rd!=0`.
- Every edge: `wb<=mem`, `mem<=ex`. Then `ex` loads as follows:
  - `ex<=ID inputs` normally.
  - `ex<=bubble` (all zero) when `stall=1` or `flush=1`.
- Select codes follow `MUX_4` order:
  - 0: register-file read.
  - 1: EX/MEM ALU result.
  - 2: MEM/WB write-back data.
  - 3: see Configuration.
- `ex_rs_sel` is registered at the edge the ID instruction enters EX. Decision order:
  1. `id_rs_used=0` or `id_rs=0`: 0.
  2. `id_rs` matches the forwardable `ex_rd`: 1 (the producer will be in MEM).
  3. `id_rs` matches the forwardable `mem_rd`: 2.
  4. Otherwise 0.
- `ex_rt_sel` is identical using the rt inputs.
- When `stall` or `flush` is active, both sel registers load 0 at that edge, matching the bubble.
- `stall` is combinational: `ex_memread & ex_regwrite & ex_rd!=0 & ((id_rs_used & id_rs==ex_rd) | (id_rt_used & id_rt==ex_rd))`.
- After a one-cycle stall, the load is in MEM and the consumer, re-presented on the ID inputs, gets sel=2.
- `flush` and `stall` in the same cycle: flush wins. The bubble is inserted and `stall_cnt` does not increment.
- `stall_cnt` increments on each edge where `stall=1` and `flush=0`. It saturates at all-ones.

## Timing
- `rst`, at any time and asynchronously: all stage records, both sel outputs and `stall_cnt` go to 0, so `stall=0`. A reset mid-stall drops the stall immediately.
- Sel latency: ID inputs at cycle t produce `ex_*_sel` valid throughout cycle t+1.
- `stall` is valid in the same cycle as the ID inputs. There is no back-to-back stall for the same consumer.
- No handshake: the pipeline advances every cycle, except that `stall` freezes the upstream stages.

## Configuration
- `WB_BYPASS_EN` defined:
  - Adds a `wb_data` input (32 bits) and a `byp_data` output (32 bits, reset 0). `byp_data` registers `wb_data` whenever the `wb` record is forwardable.
  - Adds a priority-4 rule: source matches the forwardable `wb_rd`, giving sel=3. The operand mux's IN4 takes `byp_data`.
  - This supports a register file without write-through.
- `WB_BYPASS_EN` undefined:
  - No extra ports; sel is never 3.
  - The register file must write in the first half-cycle and read in the second.

## Test plan
- Reset asserted mid-sequence with a load in EX and `stall=1`: all outputs read 0 at once, including `stall=0` and `stall_cnt=0`.
- `add $3` then `sub` reading `$3` as rs: next cycle `ex_rs_sel=1`, `ex_rt_sel=0`. The same sequence with one independent instruction between gives `ex_rs_sel=2`.
- Writer to `$0` followed by a reader of `$0`: sel=0, `stall=0`.
- `lw $5` followed by a reader of `$5` as rt: `stall=1` for exactly one cycle, then `ex_rt_sel=2`, and `stall_cnt` goes 0 to 1.
- `lw $5` in EX, reader in ID and `flush=1`: `stall` high combinationally but not counted, and the EX record becomes a bubble with sel=0.
- Writes to `$7` in both EX and MEM, then a reader of `$7`: sel=1 (newest wins). With `WB_BYPASS_EN`, a producer three instructions ahead gives sel=3 and `byp_data` equals the last `wb_data`.

Source files
------------

// File: rtl/fwd_sel_unit.sv
`default_nettype none
// ============================================================================
// fwd_sel_unit: operand forwarding selects and load-use stall for EX stage.
// Optional macro WB_BYPASS_EN adds a WB-stage bypass (sel=3, byp_data).
// Revision: 1.0
// ============================================================================
module fwd_sel_unit #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             flush,
`ifdef WB_BYPASS_EN
    input  logic [31:0]      wb_data,
    output logic [31:0]      byp_data,
`endif
    output logic [1:0]       ex_rs_sel,
    output logic [1:0]       ex_rt_sel,
    output logic             stall,
    output logic [CNT_W-1:0] stall_cnt
);

    // memread only matters while the record sits in EX, so later stages drop it
    logic [REG_W-1:0] r_ex_rd;
    logic             r_ex_regwrite;
    logic             r_ex_memread;
    logic [REG_W-1:0] r_mem_rd;
    logic             r_mem_regwrite;
`ifdef WB_BYPASS_EN
    logic [REG_W-1:0] r_wb_rd;
    logic             r_wb_regwrite;
    logic             w_wb_fwd;
`endif

    logic             w_ex_fwd;
    logic             w_mem_fwd;
    logic             w_bubble;
    logic [1:0]       w_rs_sel;
    logic [1:0]       w_rt_sel;

    assign w_ex_fwd  = r_ex_regwrite  && (r_ex_rd  != '0);
    assign w_mem_fwd = r_mem_regwrite && (r_mem_rd != '0);
`ifdef WB_BYPASS_EN
    assign w_wb_fwd  = r_wb_regwrite  && (r_wb_rd  != '0);
`endif

    assign stall = r_ex_memread && w_ex_fwd &&
                   ((id_rs_used && (id_rs == r_ex_rd)) ||
                    (id_rt_used && (id_rt == r_ex_rd)));

    assign w_bubble = stall || flush;

    // Newest producer wins: EX (result in MEM next) before MEM before WB.
    function automatic logic [1:0] pick_sel(input logic used, input logic [REG_W-1:0] src);
        logic [1:0] sel;
        sel = 2'd0;
        if (used && (src != '0)) begin
            if (w_ex_fwd && (src == r_ex_rd)) begin
                sel = 2'd1;
            end else if (w_mem_fwd && (src == r_mem_rd)) begin
                sel = 2'd2;
`ifdef WB_BYPASS_EN
            end else if (w_wb_fwd && (src == r_wb_rd)) begin
                sel = 2'd3;
`endif
            end
        end
        return sel;
    endfunction

    always_comb begin
        w_rs_sel = pick_sel(id_rs_used, id_rs);
        w_rt_sel = pick_sel(id_rt_used, id_rt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex_rd        <= '0;
            r_ex_regwrite  <= 1'b0;
            r_ex_memread   <= 1'b0;
            r_mem_rd       <= '0;
            r_mem_regwrite <= 1'b0;
            ex_rs_sel      <= 2'd0;
            ex_rt_sel      <= 2'd0;
        end else begin
            r_mem_rd       <= r_ex_rd;
            r_mem_regwrite <= r_ex_regwrite;
            if (w_bubble) begin
                r_ex_rd       <= '0;
                r_ex_regwrite <= 1'b0;
                r_ex_memread  <= 1'b0;
                ex_rs_sel     <= 2'd0;
                ex_rt_sel     <= 2'd0;
            end else begin
                r_ex_rd       <= id_rd;
                r_ex_regwrite <= id_regwrite;
                r_ex_memread  <= id_memread;
                ex_rs_sel     <= w_rs_sel;
                ex_rt_sel     <= w_rt_sel;
            end
        end
    end

`ifdef WB_BYPASS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb_rd       <= '0;
            r_wb_regwrite <= 1'b0;
            byp_data      <= '0;
        end else begin
            r_wb_rd       <= r_mem_rd;
            r_wb_regwrite <= r_mem_regwrite;
            if (w_wb_fwd) begin
                byp_data <= wb_data;
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall && !flush && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fwd_sel_unit.sv
`default_nettype none
// ============================================================================
// tb_fwd_sel_unit: table vectors, corner sequences and random run vs. model.
// Revision: 1.0
// ============================================================================
module tb_fwd_sel_unit;

    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;
`ifdef WB_BYPASS_EN
    localparam int DEPTH = 3;
`else
    localparam int DEPTH = 2;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    id_rs, id_rt, id_rd;
    logic          id_rs_used, id_rt_used, id_regwrite, id_memread, flush;
    logic [1:0]    ex_rs_sel, ex_rt_sel;
    logic          stall;
    logic [CW-1:0] stall_cnt;
`ifdef WB_BYPASS_EN
    logic [31:0]   wb_data;
    logic [31:0]   byp_data;
    logic [31:0]   m_byp;
`endif

    always #5 clk = ~clk;

    fwd_sel_unit #(.REG_W(5), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .flush(flush),
`ifdef WB_BYPASS_EN
        .wb_data(wb_data), .byp_data(byp_data),
`endif
        .ex_rs_sel(ex_rs_sel), .ex_rt_sel(ex_rt_sel),
        .stall(stall), .stall_cnt(stall_cnt)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: history of instructions that entered EX, newest first.
    typedef struct { logic [4:0] rd; logic rw; logic mr; } rec_t;
    rec_t hist [3];
    int   m_cnt;
    logic s_stall;

    function automatic bit fwd_ok(input rec_t r);
        return r.rw && (r.rd != 0);
    endfunction

    function automatic logic [1:0] m_sel(input logic used, input logic [4:0] src);
        if (!used || src == 0) return 2'd0;
        for (int k = 0; k < DEPTH; k++)
            if (fwd_ok(hist[k]) && hist[k].rd == src) return 2'(k + 1);
        return 2'd0;
    endfunction

    function automatic logic m_stall(input logic [4:0] rs, rt, input logic rsu, rtu);
        return hist[0].mr && fwd_ok(hist[0]) &&
               ((rsu && rs == hist[0].rd) || (rtu && rt == hist[0].rd));
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) hist[k] = '{rd: 5'd0, rw: 1'b0, mr: 1'b0};
        m_cnt = 0;
`ifdef WB_BYPASS_EN
        m_byp = 32'd0;
`endif
    endtask

    // Called at posedge+1; returns at the next posedge+1.
    task automatic step(input logic [4:0] rs, rt, input logic rsu, rtu,
                        input logic [4:0] rd, input logic rw, mr, fl);
        logic ms;
        logic [1:0] es, et;
        id_rs = rs; id_rt = rt; id_rs_used = rsu; id_rt_used = rtu;
        id_rd = rd; id_regwrite = rw; id_memread = mr; flush = fl;
`ifdef WB_BYPASS_EN
        wb_data = $urandom;
`endif
        @(negedge clk);
        ms = m_stall(rs, rt, rsu, rtu);
        s_stall = stall;
        chk("stall", int'(stall), int'(ms));
        es = (ms || fl) ? 2'd0 : m_sel(rsu, rs);
        et = (ms || fl) ? 2'd0 : m_sel(rtu, rt);
`ifdef WB_BYPASS_EN
        if (fwd_ok(hist[2])) m_byp = wb_data;
`endif
        hist[2] = hist[1];
        hist[1] = hist[0];
        if (ms || fl) hist[0] = '{rd: 5'd0, rw: 1'b0, mr: 1'b0};
        else          hist[0] = '{rd: rd, rw: rw, mr: mr};
        if (ms && !fl && m_cnt != CMAX) m_cnt++;
        @(posedge clk);
        #1;
        chk("rs_sel", int'(ex_rs_sel), int'(es));
        chk("rt_sel", int'(ex_rt_sel), int'(et));
        chk("stall_cnt", int'(stall_cnt), m_cnt);
`ifdef WB_BYPASS_EN
        chk("byp_data", int'(byp_data), int'(m_byp));
`endif
    endtask

    typedef struct {
        logic [4:0] rs, rt; logic rsu, rtu; logic [4:0] rd; logic rw, mr, fl;
        logic e_stall; logic [1:0] e_rs, e_rt; int e_cnt;
    } vec_t;
    vec_t tbl [16];

    function automatic vec_t mk(input int rs, rt, rsu, rtu, rd, rw, mr, fl,
                                input int st, ers, ert, cnt);
        vec_t v;
        v.rs = 5'(rs); v.rt = 5'(rt); v.rsu = 1'(rsu); v.rtu = 1'(rtu);
        v.rd = 5'(rd); v.rw = 1'(rw); v.mr = 1'(mr); v.fl = 1'(fl);
        v.e_stall = 1'(st); v.e_rs = 2'(ers); v.e_rt = 2'(ert); v.e_cnt = cnt;
        return v;
    endfunction

    initial begin
        logic [4:0] rs, rt, rd;
        logic rsu, rtu, rw, mr, fl, hold;

        //               rs rt su tu rd rw mr fl  stall rs rt cnt
        tbl[0]  = mk(1, 2, 1, 1, 3, 1, 0, 0,  0, 0, 0, 0);  // add $3
        tbl[1]  = mk(3, 6, 1, 1, 4, 1, 0, 0,  0, 1, 0, 0);  // sub reads $3 -> EX fwd
        tbl[2]  = mk(1, 2, 1, 1, 3, 1, 0, 0,  0, 0, 0, 0);  // add $3
        tbl[3]  = mk(9,10, 1, 1, 8, 1, 0, 0,  0, 0, 0, 0);  // independent
        tbl[4]  = mk(3,11, 1, 1,12, 1, 0, 0,  0, 2, 0, 0);  // reads $3 -> MEM fwd
        tbl[5]  = mk(1, 2, 1, 1, 0, 1, 0, 0,  0, 0, 0, 0);  // write $0
        tbl[6]  = mk(0, 0, 1, 1,13, 1, 0, 0,  0, 0, 0, 0);  // read $0
        tbl[7]  = mk(1, 5, 1, 0, 5, 1, 1, 0,  0, 0, 0, 0);  // lw $5
        tbl[8]  = mk(2, 5, 1, 1,14, 1, 0, 0,  1, 0, 0, 1);  // load-use on rt
        tbl[9]  = mk(2, 5, 1, 1,14, 1, 0, 0,  0, 0, 2, 1);  // replay -> MEM fwd
        tbl[10] = mk(1, 2, 1, 1, 7, 1, 0, 0,  0, 0, 0, 1);  // write $7
        tbl[11] = mk(1, 2, 1, 1, 7, 1, 0, 0,  0, 0, 0, 1);  // write $7
        tbl[12] = mk(7, 7, 1, 1,15, 1, 0, 0,  0, 1, 1, 1);  // newest $7 wins
        tbl[13] = mk(1, 0, 1, 0, 5, 1, 1, 0,  0, 0, 0, 1);  // lw $5
        tbl[14] = mk(5, 2, 1, 1,16, 1, 0, 1,  1, 0, 0, 1);  // load-use + flush
        tbl[15] = mk(1, 2, 1, 1,17, 1, 0, 0,  0, 0, 0, 1);  // after flush bubble

        rst = 1'b1;
        id_rs = 0; id_rt = 0; id_rs_used = 0; id_rt_used = 0;
        id_rd = 0; id_regwrite = 0; id_memread = 0; flush = 0;
`ifdef WB_BYPASS_EN
        wb_data = 32'd0;
`endif
        model_reset();
        #2;
        chk("rst_rs_sel", int'(ex_rs_sel), 0);
        chk("rst_rt_sel", int'(ex_rt_sel), 0);
        chk("rst_stall", int'(stall), 0);
        chk("rst_cnt", int'(stall_cnt), 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].rs, tbl[i].rt, tbl[i].rsu, tbl[i].rtu,
                 tbl[i].rd, tbl[i].rw, tbl[i].mr, tbl[i].fl);
            chk($sformatf("tbl%0d_stall", i), int'(s_stall), int'(tbl[i].e_stall));
            chk($sformatf("tbl%0d_rs", i), int'(ex_rs_sel), int'(tbl[i].e_rs));
            chk($sformatf("tbl%0d_rt", i), int'(ex_rt_sel), int'(tbl[i].e_rt));
            chk($sformatf("tbl%0d_cnt", i), int'(stall_cnt), tbl[i].e_cnt);
        end

`ifdef WB_BYPASS_EN
        step(1, 2, 1, 1, 20, 1, 0, 0);
        step(1, 2, 1, 1, 21, 1, 0, 0);
        step(1, 2, 1, 1, 22, 1, 0, 0);
        step(20, 3, 1, 0, 23, 1, 0, 0);
        chk("wb_byp_sel", int'(ex_rs_sel), 3);
        chk("wb_byp_data", int'(byp_data), int'(wb_data));
`endif

        hold = 1'b0;
        rs = 0; rt = 0; rsu = 0; rtu = 0; rd = 0; rw = 0; mr = 0; fl = 0;
        for (int n = 0; n < 400; n++) begin
            if (!hold) begin
                rs  = 5'($urandom_range(0, 7));
                rt  = 5'($urandom_range(0, 7));
                rsu = 1'($urandom_range(0, 1));
                rtu = 1'($urandom_range(0, 1));
                rd  = 5'($urandom_range(0, 7));
                rw  = ($urandom_range(0, 3) != 0);
                mr  = rw && ($urandom_range(0, 2) == 0);
            end
            fl = ($urandom_range(0, 7) == 0);
            hold = m_stall(rs, rt, rsu, rtu) && !fl;
            step(rs, rt, rsu, rtu, rd, rw, mr, fl);
        end

        // Asynchronous reset in the middle of a load-use stall.
        step(1, 0, 1, 0, 5, 1, 1, 0);
        id_rs = 2; id_rt = 5; id_rs_used = 1; id_rt_used = 1;
        id_rd = 9; id_regwrite = 1; id_memread = 0; flush = 0;
        #2;
        chk("pre_rst_stall", int'(stall), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_stall", int'(stall), 0);
        chk("mid_rst_rs_sel", int'(ex_rs_sel), 0);
        chk("mid_rst_rt_sel", int'(ex_rt_sel), 0);
        chk("mid_rst_cnt", int'(stall_cnt), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        step(2, 5, 1, 1, 9, 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
